// File: rtl/axi_bus_target.sv
// AXI4 slave endpoint backed by a word-addressed, byte-writable memory; one transaction per direction.
// Latency: AW -> w_ready next cycle, last W -> b_valid next cycle, AR -> first r_valid next cycle, 1 beat/cycle.
// Backpressure: B and R payloads are held until b_ready / r_ready; a new AW/AR waits for the previous one to finish.

package axi_bus_target_pkg;

    typedef struct packed {
        logic [5:0]  id;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic        lock;
        logic [3:0]  cache;
        logic [2:0]  prot;
        logic [3:0]  qos;
        logic [3:0]  region;
        logic [0:0]  user;
    } ax_chan_t;

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  strb;
        logic        last;
        logic [0:0]  user;
    } w_chan_t;

    typedef struct packed {
        logic [5:0] id;
        logic [1:0] resp;
        logic [0:0] user;
    } b_chan_t;

    typedef struct packed {
        logic [5:0]  id;
        logic [63:0] data;
        logic [1:0]  resp;
        logic        last;
        logic [0:0]  user;
    } r_chan_t;

    typedef struct packed {
        ax_chan_t aw;
        logic     aw_valid;
        w_chan_t  w;
        logic     w_valid;
        logic     b_ready;
        ax_chan_t ar;
        logic     ar_valid;
        logic     r_ready;
    } req_t;

    typedef struct packed {
        logic    aw_ready;
        logic    w_ready;
        b_chan_t b;
        logic    b_valid;
        logic    ar_ready;
        r_chan_t r;
        logic    r_valid;
    } resp_t;

endpackage

module axi_bus_target #(
    parameter int unsigned AXI_AW    = 32,
    parameter int unsigned AXI_DW    = 64,
    parameter int unsigned AXI_IW    = 6,
    parameter int unsigned AXI_UW    = 1,
    parameter int unsigned MEM_WORDS = 256,
    parameter type req_t  = axi_bus_target_pkg::req_t,
    parameter type resp_t = axi_bus_target_pkg::resp_t
) (
    input  logic  clk_i,
    input  logic  rst_ni,
    input  req_t  axi_req_i,
    output resp_t axi_rsp_o
);

    localparam int unsigned BYTES = AXI_DW / 8;
    localparam int unsigned OFS   = $clog2(BYTES);
    localparam int unsigned IDX_W = $clog2(MEM_WORDS);
    localparam logic [AXI_AW:0] MEM_BYTES = (AXI_AW + 1)'(MEM_WORDS * BYTES);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] BURST_FIXED = 2'b00;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_e;
    typedef enum logic       {R_IDLE, R_DATA}         rd_state_e;

    logic [AXI_DW-1:0] r_mem [MEM_WORDS];

    // write side state
    wr_state_e         r_wr_state;
    logic              r_aw_rdy;
    logic              r_w_rdy;
    logic              r_b_vld;
    logic [1:0]        r_b_resp;
    logic [AXI_IW-1:0] r_wid;
    logic [AXI_AW-1:0] r_waddr;
    logic [7:0]        r_wlen;
    logic [7:0]        r_wcnt;
    logic [2:0]        r_wsize;
    logic [1:0]        r_wburst;
    logic              r_werr;

    // read side state
    rd_state_e         r_rd_state;
    logic              r_ar_rdy;
    logic              r_r_vld;
    logic [AXI_IW-1:0] r_rid;
    logic [AXI_AW-1:0] r_raddr;
    logic [7:0]        r_rlen;
    logic [7:0]        r_rcnt;
    logic [2:0]        r_rsize;
    logic [1:0]        r_rburst;

    logic              w_win_range;
    logic [IDX_W-1:0]  w_widx;
    logic [AXI_AW-1:0] w_wnext;
    logic              w_wr_en;
    logic              w_rin_range;
    logic [IDX_W-1:0]  w_ridx;
    logic [AXI_AW-1:0] w_rnext;
    logic [AXI_DW-1:0] w_rdata;
    logic              w_rlast;
    logic              w_unused;

    // Beat address decode; WRAP is walked like INCR, FIXED keeps the start address.
    assign w_win_range = ({1'b0, r_waddr} < MEM_BYTES);
    assign w_widx      = r_waddr[OFS +: IDX_W];
    assign w_wnext     = (r_wburst == BURST_FIXED) ? r_waddr : r_waddr + (AXI_AW'(1) << r_wsize);
    assign w_wr_en     = (r_wr_state == W_DATA) && r_w_rdy && axi_req_i.w_valid && w_win_range;

    assign w_rin_range = ({1'b0, r_raddr} < MEM_BYTES);
    assign w_ridx      = r_raddr[OFS +: IDX_W];
    assign w_rnext     = (r_rburst == BURST_FIXED) ? r_raddr : r_raddr + (AXI_AW'(1) << r_rsize);
    assign w_rdata     = (r_r_vld && w_rin_range) ? r_mem[w_ridx] : '0;
    assign w_rlast     = r_r_vld && (r_rcnt == r_rlen);

    // Request fields this target has no use for.
    assign w_unused = ^{axi_req_i.aw.lock, axi_req_i.aw.cache, axi_req_i.aw.prot, axi_req_i.aw.qos,
                        axi_req_i.aw.region, axi_req_i.aw.user, axi_req_i.ar.lock, axi_req_i.ar.cache,
                        axi_req_i.ar.prot, axi_req_i.ar.qos, axi_req_i.ar.region, axi_req_i.ar.user,
                        axi_req_i.w.last, axi_req_i.w.user};

    // Storage: cleared on reset, byte-strobed writes; reads see the old word in the write cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < MEM_WORDS; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_wr_en) begin
            for (int b = 0; b < BYTES; b++) begin
                if (axi_req_i.w.strb[b]) begin
                    r_mem[w_widx][b*8 +: 8] <= axi_req_i.w.data[b*8 +: 8];
                end
            end
        end
    end

    // Write FSM: accept AW, count len+1 W beats (w.last ignored), then hold B until taken.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wr_state <= W_IDLE;
            r_aw_rdy   <= 1'b0;
            r_w_rdy    <= 1'b0;
            r_b_vld    <= 1'b0;
            r_b_resp   <= RESP_OKAY;
            r_wid      <= '0;
            r_waddr    <= '0;
            r_wlen     <= '0;
            r_wcnt     <= '0;
            r_wsize    <= '0;
            r_wburst   <= '0;
            r_werr     <= 1'b0;
        end else begin
            case (r_wr_state)
                W_IDLE: begin
                    if (r_aw_rdy && axi_req_i.aw_valid) begin
                        r_wid      <= axi_req_i.aw.id;
                        r_waddr    <= axi_req_i.aw.addr;
                        r_wlen     <= axi_req_i.aw.len;
                        r_wsize    <= axi_req_i.aw.size;
                        r_wburst   <= axi_req_i.aw.burst;
                        r_wcnt     <= '0;
                        r_werr     <= 1'b0;
                        r_aw_rdy   <= 1'b0;
                        r_w_rdy    <= 1'b1;
                        r_wr_state <= W_DATA;
                    end else begin
                        r_aw_rdy <= 1'b1;
                    end
                end
                W_DATA: begin
                    if (axi_req_i.w_valid) begin
                        if (!w_win_range) begin
                            r_werr <= 1'b1;
                        end
                        if (r_wcnt == r_wlen) begin
                            r_w_rdy    <= 1'b0;
                            r_b_vld    <= 1'b1;
                            r_b_resp   <= (r_werr || !w_win_range) ? RESP_SLVERR : RESP_OKAY;
                            r_wr_state <= W_RESP;
                        end else begin
                            r_wcnt  <= r_wcnt + 8'd1;
                            r_waddr <= w_wnext;
                        end
                    end
                end
                W_RESP: begin
                    if (axi_req_i.b_ready) begin
                        r_b_vld    <= 1'b0;
                        r_b_resp   <= RESP_OKAY;
                        r_aw_rdy   <= 1'b1;
                        r_wr_state <= W_IDLE;
                    end
                end
                default: begin
                    r_wr_state <= W_IDLE;
                end
            endcase
        end
    end

    // Read FSM: accept AR, then present one beat per r_ready handshake until beat len+1.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rd_state <= R_IDLE;
            r_ar_rdy   <= 1'b0;
            r_r_vld    <= 1'b0;
            r_rid      <= '0;
            r_raddr    <= '0;
            r_rlen     <= '0;
            r_rcnt     <= '0;
            r_rsize    <= '0;
            r_rburst   <= '0;
        end else begin
            case (r_rd_state)
                R_IDLE: begin
                    if (r_ar_rdy && axi_req_i.ar_valid) begin
                        r_rid      <= axi_req_i.ar.id;
                        r_raddr    <= axi_req_i.ar.addr;
                        r_rlen     <= axi_req_i.ar.len;
                        r_rsize    <= axi_req_i.ar.size;
                        r_rburst   <= axi_req_i.ar.burst;
                        r_rcnt     <= '0;
                        r_ar_rdy   <= 1'b0;
                        r_r_vld    <= 1'b1;
                        r_rd_state <= R_DATA;
                    end else begin
                        r_ar_rdy <= 1'b1;
                    end
                end
                R_DATA: begin
                    if (axi_req_i.r_ready) begin
                        if (r_rcnt == r_rlen) begin
                            r_r_vld    <= 1'b0;
                            r_ar_rdy   <= 1'b1;
                            r_rd_state <= R_IDLE;
                        end else begin
                            r_rcnt  <= r_rcnt + 8'd1;
                            r_raddr <= w_rnext;
                        end
                    end
                end
                default: begin
                    r_rd_state <= R_IDLE;
                end
            endcase
        end
    end

    // Response struct assembly; payloads are zero whenever their valid is low.
    always_comb begin
        axi_rsp_o          = '0;
        axi_rsp_o.aw_ready = r_aw_rdy;
        axi_rsp_o.w_ready  = r_w_rdy;
        axi_rsp_o.b_valid  = r_b_vld;
        axi_rsp_o.b.id     = r_b_vld ? r_wid : '0;
        axi_rsp_o.b.resp   = r_b_resp;
        axi_rsp_o.ar_ready = r_ar_rdy;
        axi_rsp_o.r_valid  = r_r_vld;
        axi_rsp_o.r.id     = r_r_vld ? r_rid : '0;
        axi_rsp_o.r.data   = w_rdata;
        axi_rsp_o.r.resp   = (r_r_vld && !w_rin_range) ? RESP_SLVERR : RESP_OKAY;
        axi_rsp_o.r.last   = w_rlast;
    end

endmodule

// File: tb/tb_axi_bus_target.sv
// Directed bench for axi_bus_target: single/burst writes and reads, strobes, stalls, range errors, reset.
// Inputs change and outputs are sampled on the falling edge of clk_i.
// Every wait on the DUT is bounded; a timeout counts as a failed check.

module tb_axi_bus_target;
    import axi_bus_target_pkg::*;

    logic  clk_i;
    logic  rst_ni;
    req_t  req;
    resp_t rsp;

    int checks = 0;
    int errors = 0;

    logic [63:0] wdat   [16];
    logic [63:0] exp_rd [16];

    axi_bus_target dut (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .axi_req_i (req),
        .axi_rsp_o (rsp)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Full write transaction; caller is at a falling edge.
    task automatic axi_wr(input logic [31:0] addr, input logic [7:0] len, input logic [5:0] id,
                          input logic [7:0] strb, input logic [1:0] exp_resp);
        int cnt;
        req.aw       = '0;
        req.aw.id    = id;
        req.aw.addr  = addr;
        req.aw.len   = len;
        req.aw.size  = 3'd3;
        req.aw.burst = 2'b01;
        req.aw_valid = 1'b1;
        cnt = 0;
        while (!rsp.aw_ready && cnt < 50) begin
            @(negedge clk_i);
            cnt++;
        end
        chk("aw_handshake", cnt < 50, 1'b1);
        @(negedge clk_i);
        req.aw_valid = 1'b0;
        chk("w_ready_latency", rsp.w_ready, 1'b1);
        chk("aw_ready_busy", rsp.aw_ready, 1'b0);
        for (int i = 0; i <= int'(len); i++) begin
            req.w.data  = wdat[i];
            req.w.strb  = strb;
            req.w.last  = (i == int'(len));
            req.w_valid = 1'b1;
            cnt = 0;
            while (!rsp.w_ready && cnt < 50) begin
                @(negedge clk_i);
                cnt++;
            end
            chk("w_handshake", cnt < 50, 1'b1);
            @(negedge clk_i);
        end
        req.w_valid = 1'b0;
        chk("b_valid_latency", rsp.b_valid, 1'b1);
        chk("b_id", rsp.b.id, id);
        chk("b_resp", rsp.b.resp, exp_resp);
        req.b_ready = 1'b1;
        @(negedge clk_i);
        req.b_ready = 1'b0;
        chk("b_valid_drop", rsp.b_valid, 1'b0);
    endtask

    // Full read transaction checked beat by beat against exp_rd; tog stalls with r_ready 1,0,0,1,...
    task automatic axi_rd(input logic [31:0] addr, input logic [7:0] len, input logic [5:0] id,
                          input logic tog, input logic [1:0] exp_resp);
        int cnt;
        int beats;
        req.ar       = '0;
        req.ar.id    = id;
        req.ar.addr  = addr;
        req.ar.len   = len;
        req.ar.size  = 3'd3;
        req.ar.burst = 2'b01;
        req.ar_valid = 1'b1;
        cnt = 0;
        while (!rsp.ar_ready && cnt < 50) begin
            @(negedge clk_i);
            cnt++;
        end
        chk("ar_handshake", cnt < 50, 1'b1);
        @(negedge clk_i);
        req.ar_valid = 1'b0;
        chk("r_valid_latency", rsp.r_valid, 1'b1);
        beats = 0;
        cnt   = 0;
        while (beats <= int'(len) && cnt < 100) begin
            req.r_ready = tog ? ((cnt % 4 == 0) || (cnt % 4 == 3)) : 1'b1;
            if (rsp.r_valid) begin
                chk("r_data", rsp.r.data, exp_rd[beats]);
                chk("r_last", rsp.r.last, beats == int'(len));
                chk("r_resp", rsp.r.resp, exp_resp);
                chk("r_id", rsp.r.id, id);
            end
            if (rsp.r_valid && req.r_ready) beats++;
            @(negedge clk_i);
            cnt++;
        end
        req.r_ready = 1'b0;
        chk("r_beat_count", beats, int'(len) + 1);
        chk("r_valid_idle", rsp.r_valid, 1'b0);
    endtask

    initial begin
        int cnt;
        req    = '0;
        rst_ni = 1'b0;
        repeat (3) @(negedge clk_i);

        // Reset state
        chk("rst_aw_ready", rsp.aw_ready, 1'b0);
        chk("rst_w_ready", rsp.w_ready, 1'b0);
        chk("rst_b_valid", rsp.b_valid, 1'b0);
        chk("rst_ar_ready", rsp.ar_ready, 1'b0);
        chk("rst_r_valid", rsp.r_valid, 1'b0);
        chk("rst_r_data", rsp.r.data, 64'h0);
        rst_ni = 1'b1;
        @(negedge clk_i);
        chk("post_rst_aw_ready", rsp.aw_ready, 1'b1);
        chk("post_rst_ar_ready", rsp.ar_ready, 1'b1);

        // Single write/read at 0x0
        wdat[0] = 64'hDEADBEEF_CAFEBABE;
        axi_wr(32'h0, 8'd0, 6'd5, 8'hFF, 2'b00);
        exp_rd[0] = 64'hDEADBEEF_CAFEBABE;
        axi_rd(32'h0, 8'd0, 6'd3, 1'b0, 2'b00);

        // Partial-strobe overwrite at 0x8
        wdat[0] = 64'h11223344_55667788;
        axi_wr(32'h8, 8'd0, 6'd1, 8'hFF, 2'b00);
        wdat[0] = 64'hFFFFFFFF_FFFFFFFF;
        axi_wr(32'h8, 8'd0, 6'd2, 8'h0F, 2'b00);
        exp_rd[0] = 64'h11223344_FFFFFFFF;
        axi_rd(32'h8, 8'd0, 6'd4, 1'b0, 2'b00);

        // INCR burst of four beats at 0x100
        for (int i = 0; i < 4; i++) begin
            wdat[i]   = 64'(i + 1);
            exp_rd[i] = 64'(i + 1);
        end
        axi_wr(32'h100, 8'd3, 6'd7, 8'hFF, 2'b00);
        axi_rd(32'h100, 8'd3, 6'd9, 1'b0, 2'b00);

        // Same burst read back with r_ready stalls
        axi_rd(32'h100, 8'd3, 6'd10, 1'b1, 2'b00);

        // Out-of-range write must not alias onto word 0
        wdat[0] = 64'h55555555_55555555;
        axi_wr(32'h800, 8'd0, 6'd11, 8'hFF, 2'b10);
        exp_rd[0] = 64'hDEADBEEF_CAFEBABE;
        axi_rd(32'h0, 8'd0, 6'd12, 1'b0, 2'b00);
        exp_rd[0] = 64'h0;
        axi_rd(32'h800, 8'd0, 6'd13, 1'b0, 2'b10);

        // Reset in the middle of a stalled read burst
        req.ar       = '0;
        req.ar.id    = 6'd14;
        req.ar.addr  = 32'h100;
        req.ar.len   = 8'd3;
        req.ar.size  = 3'd3;
        req.ar.burst = 2'b01;
        req.ar_valid = 1'b1;
        req.r_ready  = 1'b0;
        cnt = 0;
        while (!rsp.ar_ready && cnt < 50) begin
            @(negedge clk_i);
            cnt++;
        end
        chk("mid_ar_handshake", cnt < 50, 1'b1);
        @(negedge clk_i);
        req.ar_valid = 1'b0;
        chk("mid_r_valid", rsp.r_valid, 1'b1);
        chk("mid_r_data", rsp.r.data, 64'h1);
        #2 rst_ni = 1'b0;
        #1;
        chk("mid_rst_r_valid", rsp.r_valid, 1'b0);
        chk("mid_rst_ar_ready", rsp.ar_ready, 1'b0);
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        chk("rel_ar_ready", rsp.ar_ready, 1'b1);
        chk("rel_r_valid", rsp.r_valid, 1'b0);
        exp_rd[0] = 64'h0;
        axi_rd(32'h0, 8'd0, 6'd15, 1'b0, 2'b00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
